// File: rtl/regfile_pkg.sv
// Shared defaults and opcode constants for the register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_LINK_REG = 14;

  // Opcodes that interact with the register file's dual-word and link paths.
  localparam logic [3:0] LDW = 4'd8;
  localparam logic [3:0] SDW = 4'd9;
  localparam logic [3:0] CLL = 4'd15;

endpackage : regfile_pkg

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer, gates issue on WAW hazards.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
  localparam int unsigned CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_dw,
  input  logic              wb_clr,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_dw,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              issue_ready,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [CNT_W-1:0]  pending_count
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask, busy_eff;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   issue_hi, wb_hi;
  logic                issue_mis, issue_acc;

  // Clear/set masks, WAW check and next busy state; set wins over a same-cycle clear.
  always_comb begin
    clr_mask  = '0;
    set_mask  = '0;
    issue_hi  = issue_rd + ADDR_W'(1);
    wb_hi     = wb_rd + ADDR_W'(1);
    if (wb_clr) begin
      clr_mask[wb_rd] = 1'b1;
      if (wb_dw) clr_mask[wb_hi] = 1'b1;
    end
    busy_eff    = busy_q & ~clr_mask;
    issue_ready = !busy_eff[issue_rd] && !(issue_dw && busy_eff[issue_hi]);
    issue_mis   = issue_dw && issue_rd[0];
    issue_acc   = issue_valid && issue_ready && !stall && !issue_mis;
    if (issue_acc) begin
      set_mask[issue_rd] = 1'b1;
      if (issue_dw) set_mask[issue_hi] = 1'b1;
    end
    busy_d    = busy_eff | set_mask;
    busy_d[0] = 1'b0;
    rs_busy   = busy_eff[rs_addr];
    rt_busy   = busy_eff[rt_addr];
  end

  // Popcount of the next busy vector so the registered count tracks busy_q.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Busy bits and pending count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_count = cnt_q;

endmodule : reg_scoreboard

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass, link-register port, dual-word writeback and scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned LINK_REG = DEF_LINK_REG,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_dw,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] rt_hi_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_dw,
  input  logic [DATA_W-1:0] wb_data_lo,
  input  logic [DATA_W-1:0] wb_data_hi,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_data,
  output logic              exception,
  output logic [ADDR_W:0]   pending_count
);

  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wb_mis, wb_ok, issue_mis, exception_q, exception_d;
  logic [ADDR_W-1:0] wb_hi, rt_hi_addr;

  // Writeback legality and misalignment flag for the next cycle.
  always_comb begin
    wb_mis      = wb_valid && wb_dw && wb_rd[0];
    wb_ok       = wb_valid && !wb_mis;
    issue_mis   = issue_valid && issue_dw && issue_rd[0] && !stall;
    exception_d = issue_mis || wb_mis;
    wb_hi       = wb_rd + ADDR_W'(1);
    rt_hi_addr  = rt_addr + ADDR_W'(1);
  end

  // Next register contents; link write is applied last so it beats a wb to the same register.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (!reset) begin
      if (wb_ok) begin
        regs_d[wb_rd] = wb_data_lo;
        if (wb_dw) regs_d[wb_hi] = wb_data_hi;
      end
      if (link_we) regs_d[LINK_IDX] = link_data;
    end
    regs_d[0] = '0;
  end

  // Reads see this cycle's writes (write-through bypass).
  always_comb begin
    rs_data    = regs_d[rs_addr];
    rt_data    = regs_d[rt_addr];
    rt_hi_data = regs_d[rt_hi_addr];
  end

  // Register storage and exception pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      exception_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      exception_q <= exception_d;
    end
  end

  assign exception = exception_q;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_dw      (issue_dw),
    .wb_clr        (wb_ok),
    .wb_rd         (wb_rd),
    .wb_dw         (wb_dw),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .issue_ready   (issue_ready),
    .rs_busy       (rs_busy),
    .rt_busy       (rt_busy),
    .pending_count (pending_count)
  );

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset, stall;
  logic          issue_valid, issue_dw, issue_ready;
  logic [AW-1:0] issue_rd, rs_addr, rt_addr, wb_rd;
  logic [DW-1:0] rs_data, rt_data, rt_hi_data, wb_data_lo, wb_data_hi, link_data;
  logic          rs_busy, rt_busy, wb_valid, wb_dw, link_we, exception;
  logic [AW:0]   pending_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk (clk), .reset (reset), .stall (stall),
    .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_dw (issue_dw),
    .issue_ready (issue_ready),
    .rs_addr (rs_addr), .rt_addr (rt_addr),
    .rs_data (rs_data), .rt_data (rt_data), .rt_hi_data (rt_hi_data),
    .rs_busy (rs_busy), .rt_busy (rt_busy),
    .wb_valid (wb_valid), .wb_rd (wb_rd), .wb_dw (wb_dw),
    .wb_data_lo (wb_data_lo), .wb_data_hi (wb_data_hi),
    .link_we (link_we), .link_data (link_data),
    .exception (exception), .pending_count (pending_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_dw = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_dw = 1'b0; wb_data_lo = '0; wb_data_hi = '0;
    link_we = 1'b0; link_data = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    rs_addr = 4'd1; rt_addr = 4'd2;
    tick(); tick();
    reset = 1'b0;
    #1;
    vecs++; if (pending_count !== 5'd0) begin $display("FAIL reset_count got %0d exp 0", pending_count); errs++; end
    vecs++; if (exception !== 1'b0) begin $display("FAIL reset_exc got %b exp 0", exception); errs++; end
    vecs++; if (issue_ready !== 1'b1) begin $display("FAIL reset_ready got %b exp 1", issue_ready); errs++; end
    vecs++; if (rs_data !== 32'h0) begin $display("FAIL reset_r1 got %h exp 0", rs_data); errs++; end
  endtask

  task automatic test_write_read();
    idle();
    wb_valid = 1'b1; wb_rd = 4'd1; wb_data_lo = 32'h12345678;
    rs_addr = 4'd1;
    #1;
    vecs++; if (rs_data !== 32'h12345678) begin $display("FAIL bypass_r1 got %h exp 12345678", rs_data); errs++; end
    tick();
    idle();
    #1;
    vecs++; if (rs_data !== 32'h12345678) begin $display("FAIL read_r1 got %h exp 12345678", rs_data); errs++; end
    vecs++; if (rs_busy !== 1'b0) begin $display("FAIL r1_busy got %b exp 0", rs_busy); errs++; end
    // R0 is hardwired and never becomes busy.
    wb_valid = 1'b1; wb_rd = 4'd0; wb_data_lo = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_rd = 4'd0;
    rs_addr = 4'd0;
    #1;
    vecs++; if (rs_data !== 32'h0) begin $display("FAIL r0_bypass got %h exp 0", rs_data); errs++; end
    tick();
    idle();
    #1;
    vecs++; if (rs_data !== 32'h0) begin $display("FAIL r0_read got %h exp 0", rs_data); errs++; end
    vecs++; if (pending_count !== 5'd0) begin $display("FAIL r0_count got %0d exp 0", pending_count); errs++; end
  endtask

  task automatic test_dword();
    idle();
    issue_valid = 1'b1; issue_rd = 4'd2; issue_dw = 1'b1;
    tick();
    idle();
    rs_addr = 4'd2; rt_addr = 4'd3;
    #1;
    vecs++; if (pending_count !== 5'd2) begin $display("FAIL dw_count got %0d exp 2", pending_count); errs++; end
    vecs++; if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin $display("FAIL dw_busy got %b%b exp 11", rs_busy, rt_busy); errs++; end
    wb_valid = 1'b1; wb_rd = 4'd2; wb_dw = 1'b1; wb_data_lo = 32'hA; wb_data_hi = 32'hB;
    rt_addr = 4'd2;
    #1;
    vecs++; if (rs_busy !== 1'b0) begin $display("FAIL dw_busy_bypass got %b exp 0", rs_busy); errs++; end
    vecs++; if (rt_data !== 32'hA || rt_hi_data !== 32'hB) begin $display("FAIL dw_bypass got %h/%h exp a/b", rt_data, rt_hi_data); errs++; end
    tick();
    idle();
    #1;
    vecs++; if (pending_count !== 5'd0) begin $display("FAIL dw_count_after got %0d exp 0", pending_count); errs++; end
    vecs++; if (rt_data !== 32'hA || rt_hi_data !== 32'hB) begin $display("FAIL dw_read got %h/%h exp a/b", rt_data, rt_hi_data); errs++; end
  endtask

  task automatic test_misalign();
    idle();
    issue_valid = 1'b1; issue_rd = 4'd1; issue_dw = 1'b1;
    tick();
    idle();
    #1;
    vecs++; if (exception !== 1'b1) begin $display("FAIL mis_issue_exc got %b exp 1", exception); errs++; end
    vecs++; if (pending_count !== 5'd0) begin $display("FAIL mis_issue_count got %0d exp 0", pending_count); errs++; end
    tick();
    vecs++; if (exception !== 1'b0) begin $display("FAIL mis_exc_one_cycle got %b exp 0", exception); errs++; end
    wb_valid = 1'b1; wb_rd = 4'd3; wb_dw = 1'b1; wb_data_lo = 32'h33; wb_data_hi = 32'h44;
    tick();
    idle();
    rt_addr = 4'd3;
    #1;
    vecs++; if (exception !== 1'b1) begin $display("FAIL mis_wb_exc got %b exp 1", exception); errs++; end
    vecs++; if (rt_data !== 32'hB || rt_hi_data !== 32'h0) begin $display("FAIL mis_wb_data got %h/%h exp b/0", rt_data, rt_hi_data); errs++; end
    // A misaligned issue under stall raises nothing.
    stall = 1'b1; issue_valid = 1'b1; issue_rd = 4'd7; issue_dw = 1'b1;
    tick();
    idle();
    #1;
    vecs++; if (exception !== 1'b0) begin $display("FAIL mis_stall_exc got %b exp 0", exception); errs++; end
  endtask

  task automatic test_waw_stall();
    idle();
    issue_valid = 1'b1; issue_rd = 4'd5;
    tick();
    #1;
    vecs++; if (pending_count !== 5'd1) begin $display("FAIL waw_first_count got %0d exp 1", pending_count); errs++; end
    vecs++; if (issue_ready !== 1'b0) begin $display("FAIL waw_block got %b exp 0", issue_ready); errs++; end
    tick();
    issue_rd = 4'd4; issue_dw = 1'b1;
    #1;
    vecs++; if (issue_ready !== 1'b0) begin $display("FAIL waw_dw_block got %b exp 0", issue_ready); errs++; end
    issue_rd = 4'd5; issue_dw = 1'b0;
    wb_valid = 1'b1; wb_rd = 4'd5; wb_data_lo = 32'h5;
    #1;
    vecs++; if (issue_ready !== 1'b1) begin $display("FAIL waw_wb_unblock got %b exp 1", issue_ready); errs++; end
    tick();
    issue_valid = 1'b0;
    #1;
    vecs++; if (pending_count !== 5'd1) begin $display("FAIL set_wins_count got %0d exp 1", pending_count); errs++; end
    tick();
    idle();
    #1;
    vecs++; if (pending_count !== 5'd0) begin $display("FAIL waw_release got %0d exp 0", pending_count); errs++; end
    stall = 1'b1; issue_valid = 1'b1; issue_rd = 4'd6;
    tick();
    idle();
    #1;
    vecs++; if (pending_count !== 5'd0) begin $display("FAIL stall_count got %0d exp 0", pending_count); errs++; end
  endtask

  task automatic test_link();
    idle();
    issue_valid = 1'b1; issue_rd = 4'd14;
    tick();
    idle();
    link_we = 1'b1; link_data = 32'hFF;
    wb_valid = 1'b1; wb_rd = 4'd14; wb_data_lo = 32'h1;
    rs_addr = 4'd14;
    #1;
    vecs++; if (rs_data !== 32'hFF) begin $display("FAIL link_bypass got %h exp ff", rs_data); errs++; end
    tick();
    idle();
    #1;
    vecs++; if (rs_data !== 32'hFF) begin $display("FAIL link_read got %h exp ff", rs_data); errs++; end
    vecs++; if (rs_busy !== 1'b0 || pending_count !== 5'd0) begin $display("FAIL link_busy got %b/%0d exp 0/0", rs_busy, pending_count); errs++; end
  endtask

  task automatic test_reset_mid();
    idle();
    issue_valid = 1'b1; issue_rd = 4'd5;
    tick();
    issue_rd = 4'd6;
    tick();
    idle();
    #1;
    vecs++; if (pending_count !== 5'd2) begin $display("FAIL pre_reset_count got %0d exp 2", pending_count); errs++; end
    reset = 1'b1;
    wb_valid = 1'b1; wb_rd = 4'd5; wb_data_lo = 32'h55;
    link_we = 1'b1; link_data = 32'h77;
    issue_valid = 1'b1; issue_rd = 4'd9;
    tick();
    idle();
    issue_valid = 1'b0; issue_rd = 4'd5;
    rs_addr = 4'd14; rt_addr = 4'd1;
    #1;
    vecs++; if (pending_count !== 5'd0) begin $display("FAIL mid_reset_count got %0d exp 0", pending_count); errs++; end
    vecs++; if (issue_ready !== 1'b1) begin $display("FAIL mid_reset_ready got %b exp 1", issue_ready); errs++; end
    vecs++; if (rs_data !== 32'h0 || rt_data !== 32'h0 || rt_hi_data !== 32'h0) begin
      $display("FAIL mid_reset_regs got %h/%h/%h exp 0/0/0", rs_data, rt_data, rt_hi_data); errs++;
    end
    rs_addr = 4'd5;
    #1;
    vecs++; if (rs_data !== 32'h0) begin $display("FAIL mid_reset_r5 got %h exp 0", rs_data); errs++; end
  endtask

  initial begin
    idle();
    rs_addr = '0; rt_addr = '0;
    test_reset();
    test_write_read();
    test_dword();
    test_misalign();
    test_waw_stall();
    test_link();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_regfile_scoreboard

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter NUM_REGS, default 16, register count, power of two, at least 4.
REQ-003 Parameter LINK_REG, default 14, link-register index written by the CLL link port.
REQ-004 Derived ADDR_W = clog2(NUM_REGS).
REQ-005 One clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-006 stall  in  1  blocks issue acceptance; writeback and link writes still proceed.
REQ-007 Issue ports: issue_valid  in  1  destination reservation request; issue_rd  in  ADDR_W  destination; issue_dw  in  1  double-word (Rd, Rd+1); issue_ready  out  1  reservation can be accepted.
REQ-008 Read ports: rs_addr, rt_addr  in  ADDR_W; rs_data, rt_data, rt_hi_data  out  DATA_W  (rt_hi = Rt+1 modulo NUM_REGS); rs_busy, rt_busy  out  1  pending producer.
REQ-009 Writeback ports: wb_valid  in  1; wb_rd  in  ADDR_W; wb_dw  in  1; wb_data_lo, wb_data_hi  in  DATA_W.
REQ-010 Link ports: link_we  in  1  CLL return write; link_data  in  DATA_W  return address.
REQ-011 Status: exception  out  1  registered misaligned double-word pulse; pending_count  out  ADDR_W+1  number of set busy bits.

Function
REQ-012 R0 SHALL read as 0; writes to R0 are ignored; R0 is never marked busy.
REQ-013 Reads SHALL be combinational; a same-cycle wb or link write to the read address bypasses to the output (write-through).
REQ-014 issue_ready SHALL be low when issue_rd is busy, or when issue_dw=1 and Rd+1 is busy (WAW block); a busy bit cleared by wb in the same cycle counts as not busy.
REQ-015 An issue SHALL be accepted when issue_valid & issue_ready & !stall & no misalignment. Acceptance sets busy[Rd], plus busy[Rd+1] when issue_dw=1, at the next edge.
REQ-016 An issue with issue_dw=1 and odd issue_rd SHALL NOT be accepted. exception SHALL be 1 for exactly the following cycle and set no busy bit; this applies regardless of issue_ready but not while stall=1.
REQ-017 wb_valid with wb_dw=1 and odd wb_rd SHALL write nothing and raise exception the next cycle.
REQ-018 A valid wb SHALL write wb_data_lo to Rd and clear busy[Rd]. When wb_dw=1 it also writes wb_data_hi to Rd+1 and clears busy[Rd+1]. Latency is one edge.
REQ-019 If a busy bit is set by issue and cleared by wb in the same cycle, set SHALL win.
REQ-020 link_we SHALL write link_data to LINK_REG at the next edge. Link does not touch busy.
REQ-021 If link_we and a wb target LINK_REG in the same cycle, link data SHALL win; the wb still clears the busy bit.
REQ-022 rs_busy and rt_busy SHALL reflect busy bits after same-cycle wb clears (bypass-consistent).
REQ-023 pending_count SHALL be registered, equal to the popcount of busy bits, range 0..NUM_REGS-1.

Reset
REQ-024 Reset SHALL zero all registers and busy bits, and drive exception=0, pending_count=0. issue_ready is then 1.
REQ-025 Reset SHALL take priority over a simultaneous issue, wb or link in the same cycle; all three are discarded.

Structure
REQ-026 Package regfile_pkg SHALL hold DATA_W, NUM_REGS and LINK_REG defaults, plus opcode constants LDW=8, SDW=9, CLL=15.
REQ-027 Busy tracking and pending_count SHALL live in the sub-module reg_scoreboard. Storage, bypass and the exception flag live in the top.

Verification
REQ-028 Write then read: wb R1=0x12345678, next cycle rs_addr=1 -> rs_data=0x12345678, rs_busy=0. Same-cycle read returns the bypassed value.
REQ-029 Double-word: issue rd=2 dw -> busy R2,R3, pending_count=2. wb rd=2 dw lo=0xA hi=0xB -> R2=0xA, R3=0xB, count=0.
REQ-030 Misalignment: issue rd=1 dw -> exception=1 for one cycle, no busy set. wb rd=3 dw -> exception pulse, R3 and R4 unchanged.
REQ-031 WAW and stall: issue rd=5 accepted. Then issue rd=5 -> issue_ready=0 until wb rd=5. stall=1 with a valid issue -> no busy set.
REQ-032 Link conflict: link_we with link_data=0xFF plus wb R14=0x1 in the same cycle -> R14=0xFF, busy[14] cleared.
REQ-033 Reset mid-operation: busy R5, R6 with a wb pending, reset=1 for one cycle -> all registers 0, count 0, issue_ready=1.
